// File: rtl/rca_accumulator.sv
// rca_accumulator: accumulates a fixed-length burst of operands into a
// DATA_W-bit ripple-carry sum.
// Each run starts with start/len in IDLE and accepts len operands in ACC
// (len = 0 means 2^CNT_W). The block records a sticky carry-out flag and a
// saturating count of carry-outs, then pulses done for one cycle.
// Optional feature: define ACC_SAT_EN to clamp acc_sum to all ones on carry-out
// instead of letting it wrap.
module rca_accumulator #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] acc_sum,
    output logic              acc_cout,
    output logic [CNT_W-1:0]  ovf_cnt,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The remaining-count register is one bit wider so it can hold 2^CNT_W.
    localparam logic [CNT_W:0]   REM_FULL = {1'b1, {CNT_W{1'b0}}};
    localparam logic [CNT_W:0]   REM_ONE  = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0] OVF_MAX  = '1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              cout_q, cout_d;
    logic [CNT_W-1:0]  ovf_q, ovf_d;
    logic [CNT_W:0]    rem_q, rem_d;
    logic              accept;
    logic [DATA_W:0]   add_res;

    // Ripple-carry add with a carry-in of 0. The result is {carry_out, sum}.
    // When clamping is built in, a carry-out forces the sum to all ones.
    function automatic logic [DATA_W:0] acc_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef ACC_SAT_EN
        if (s[DATA_W]) begin
            s[DATA_W-1:0] = '1;
        end
`else
        s = s;
`endif
        return s;
    endfunction

    // Saturating increment for the carry-out counter.
    function automatic logic [CNT_W-1:0] ovf_inc(input logic [CNT_W-1:0] c);
        return (c == OVF_MAX) ? c : c + CNT_W'(1);
    endfunction

    assign accept  = in_valid && (state_q == S_ACC);
    assign add_res = acc_add(sum_q, in_data);

    // Next-state logic. The last accepted operand moves to DONE.
    // DONE always falls back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_ACC;
            S_ACC:   if (accept && (rem_q == REM_ONE)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: an accepted start clears the results.
    // Each accepted operand adds into the sum and records any carry-out.
    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        rem_d  = rem_q;
        if ((state_q == S_IDLE) && start) begin
            sum_d  = '0;
            cout_d = 1'b0;
            ovf_d  = '0;
            rem_d  = (len == '0) ? REM_FULL : {1'b0, len};
        end else if (accept) begin
            sum_d = add_res[DATA_W-1:0];
            rem_d = rem_q - REM_ONE;
            if (add_res[DATA_W]) begin
                cout_d = 1'b1;
                ovf_d  = ovf_inc(ovf_q);
            end
        end
    end

    // Outputs are pure decodes of the registered state and results.
    // There is no path from in_valid to in_ready.
    always_comb begin
        in_ready = (state_q == S_ACC);
        busy     = (state_q == S_ACC) || (state_q == S_DONE);
        done     = (state_q == S_DONE);
        acc_sum  = sum_q;
        acc_cout = cout_q;
        ovf_cnt  = ovf_q;
    end

    // State and result registers. Reset overrides start and acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_rca_accumulator.sv
// Bench for rca_accumulator.
// The stimulus pushes the hand-computed result of each run into a queue.
// A monitor pops and compares the results whenever done is seen.
module tb_rca_accumulator;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] acc_sum;
    logic              acc_cout;
    logic [CNT_W-1:0]  ovf_cnt;
    logic              busy;
    logic              done;

    typedef struct {
        int sum;
        int cout;
        int ovf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic done_prev = 1'b0;

    rca_accumulator #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .acc_sum  (acc_sum),
        .acc_cout (acc_cout),
        .ovf_cnt  (ovf_cnt),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int s, input int c, input int o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        exp_q.push_back(e);
    endtask

    // Monitor: each done pulse retires one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            chk("done_one_cycle", int'(done_prev), 0);
            chk("busy_in_done", int'(busy), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_acc_sum", int'(acc_sum), e.sum);
                chk("sb_acc_cout", int'(acc_cout), e.cout);
                chk("sb_ovf_cnt", int'(ovf_cnt), e.ovf);
            end
        end
        done_prev <= done;
    end

    // All tasks are entered just after a rising edge.
    task automatic do_start(input logic [CNT_W-1:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        chk("in_ready_acc", int'(in_ready), 1);
        chk("no_early_done", int'(done), 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic finish_run();
        @(negedge clk);
        chk("done_latency", int'(done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_sum"}, int'(acc_sum), 0);
        chk({tag, "_cout"}, int'(acc_cout), 0);
        chk({tag, "_ovf"}, int'(ovf_cnt), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_ready"}, int'(in_ready), 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset held for two cycles with start also high.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_idle_zero("reset");
        @(posedge clk);
        #1;

        // Two back-to-back operands that produce a carry.
        do_start(3'd2);
`ifdef ACC_SAT_EN
        push_exp(15, 1, 1);
`else
        push_exp(10, 1, 1);
`endif
        send(4'hC);
        send(4'hE);
        finish_run();
        @(negedge clk);
        chk("idle_after_done", int'(busy), 0);
        @(posedge clk);
        #1;

        // Three operands with a three-cycle stall after the first.
        do_start(3'd3);
`ifdef ACC_SAT_EN
        push_exp(15, 1, 2);
`else
        push_exp(2, 1, 1);
`endif
        send(4'hA);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", int'(in_ready), 1);
            chk("stall_sum", int'(acc_sum), 10);
            chk("stall_busy", int'(busy), 1);
            @(posedge clk);
            #1;
        end
        send(4'h7);
        send(4'h1);
        finish_run();

        // len = 0 means eight operands. Seven carries saturate the 3-bit counter.
        do_start(3'd0);
`ifdef ACC_SAT_EN
        push_exp(15, 1, 7);
`else
        push_exp(8, 1, 7);
`endif
        for (int i = 0; i < 8; i++) send(4'hF);
        finish_run();

        // start is held high during ACC and during DONE and must be ignored.
        // It is then accepted in the following IDLE cycle.
        do_start(3'd2);
        push_exp(7, 0, 0);
        len   = 3'd5;
        start = 1'b1;
        send(4'h3);
        send(4'h4);
        len = 3'd1;
        @(negedge clk);
        chk("done_with_start", int'(done), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ignored_start_idle", int'(busy), 0);
        chk("hold_sum_idle", int'(acc_sum), 7);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("restart_busy", int'(busy), 1);
        chk("restart_clear", int'(acc_sum), 0);
        push_exp(9, 0, 0);
        @(posedge clk);
        #1;
        send(4'h9);
        finish_run();

        // Reset after one of three operands aborts the run without a done pulse.
        do_start(3'd3);
        send(4'h2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("abort");
        @(posedge clk);
        #1;
        do_start(3'd1);
        push_exp(5, 0, 0);
        send(4'h5);
        finish_run();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
